// File: rtl/tlc_pkg.sv
// Shared lamp encodings, FSM states and a small helper for the tlc_timed block.
package tlc_pkg;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    typedef enum logic [2:0] {
        S0_HWY_G  = 3'd0,
        S1_HWY_Y  = 3'd1,
        S2_AR1    = 3'd2,
        S3_CTRD_G = 3'd3,
        S4_CTRD_Y = 3'd4,
        S5_AR2    = 3'd5
    } state_t;

    // Largest of the five duration parameters; sizes the phase timer.
    function automatic int max5(input int a, input int b, input int c, input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase timer: counts cycles spent in the current phase, clears synchronously
// and sticks at all-ones so long highway greens never wrap.
module tlc_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    output logic [W-1:0] t
);

    logic [W-1:0] t_q, t_d;

    // Next count: clear wins, otherwise increment until saturated.
    always_comb begin
        t_d = t_q;
        if (clr)
            t_d = '0;
        else if (t_q != {W{1'b1}})
            t_d = t_q + W'(1);
    end

    // Count register.
    always_ff @(posedge clk) begin
        t_q <= t_d;
    end

    assign t = t_q;

endmodule

// File: rtl/tlc_timed.sv
// Two-road traffic light controller with programmable phase durations,
// country-green maximum, pedestrian walk request and debug phase output.
module tlc_timed
    import tlc_pkg::*;
#(
    parameter int HWY_MIN  = 8,
    parameter int Y_TICKS  = 3,
    parameter int AR_TICKS = 1,
    parameter int CTRD_MIN = 4,
    parameter int CTRD_MAX = 10
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       x,
    input  logic       ped,
    output logic [1:0] hwy,
    output logic [1:0] ctrd,
    output logic       walk,
    output logic [2:0] phase
);

    localparam int TMAX = max5(HWY_MIN, Y_TICKS, AR_TICKS, CTRD_MIN, CTRD_MAX);
    localparam int TW   = $clog2(TMAX + 1);

    // Last timer value of each phase (timer starts at 0 on entry).
    localparam logic [TW-1:0] HWY_LIM  = TW'(HWY_MIN - 1);
    localparam logic [TW-1:0] Y_LIM    = TW'(Y_TICKS - 1);
    localparam logic [TW-1:0] AR_LIM   = TW'(AR_TICKS - 1);
    localparam logic [TW-1:0] CMIN_LIM = TW'(CTRD_MIN - 1);
    localparam logic [TW-1:0] CMAX_LIM = TW'(CTRD_MAX - 1);

    state_t        state_q, state_d;
    logic          ped_pend_q, ped_pend_d;
    logic          walk_q, walk_d;
    logic [TW-1:0] t;
    logic          t_clr;

    // Timer restarts on every phase change and on reset.
    assign t_clr = clr | (state_d != state_q);

    tlc_phase_timer #(.W(TW)) u_timer (
        .clk (clk),
        .clr (t_clr),
        .t   (t)
    );

    // Next-state: each phase advances once its timing and demand conditions hold.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S0_HWY_G:  if (t >= HWY_LIM && (x | ped_pend_q | ped)) state_d = S1_HWY_Y;
            S1_HWY_Y:  if (t == Y_LIM)  state_d = S2_AR1;
            S2_AR1:    if (t == AR_LIM) state_d = S3_CTRD_G;
            S3_CTRD_G: if (t >= CMIN_LIM && (!x || t == CMAX_LIM)) state_d = S4_CTRD_Y;
            S4_CTRD_Y: if (t == Y_LIM)  state_d = S5_AR2;
            S5_AR2:    if (t == AR_LIM) state_d = S0_HWY_G;
            default:   state_d = S0_HWY_G;
        endcase
    end

    // Pedestrian latch and walk lamp: a pending (or same-cycle) request is
    // granted as country green starts; walk drops when country green ends.
    always_comb begin
        ped_pend_d = ped_pend_q | ped;
        walk_d     = walk_q;
        if (state_q == S2_AR1 && state_d == S3_CTRD_G) begin
            walk_d     = ped_pend_q | ped;
            ped_pend_d = 1'b0;
        end else if (state_q == S3_CTRD_G && state_d != S3_CTRD_G) begin
            walk_d = 1'b0;
        end
    end

    // State, latch and walk registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S0_HWY_G;
            ped_pend_q <= 1'b0;
            walk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ped_pend_q <= ped_pend_d;
            walk_q     <= walk_d;
        end
    end

    // Moore lamp decode; unused codes show all-red while recovering.
    always_comb begin
        hwy  = RED;
        ctrd = RED;
        case (state_q)
            S0_HWY_G:  hwy  = GREEN;
            S1_HWY_Y:  hwy  = YELLOW;
            S3_CTRD_G: ctrd = GREEN;
            S4_CTRD_Y: ctrd = YELLOW;
            default: ;
        endcase
    end

    assign walk  = walk_q;
    assign phase = state_q;

endmodule
